// File: rtl/keypad_pkg.sv
// Shared encodings for the keypad BCD entry block: scanner and entry states,
// special key codes and the hex-to-7-segment image.
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESSED  = 3'd2,
        RELEASE  = 3'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        DONE    = 2'd2
    } entry_state_t;

    localparam logic [7:0] KEY_ENTER     = 8'd10;
    localparam logic [7:0] KEY_CLEAR     = 8'd11;
    localparam logic [7:0] KEY_BACKSPACE = 8'd12;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/keypad_bcd_entry_if.sv
// Pin bundle of the keypad BCD entry block: keypad matrix, operands, status
// and the multiplexed 7-segment display.
interface keypad_bcd_entry_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DIGITS = 4
);
    logic [ROWS-1:0]     row;
    logic [COLS-1:0]     col;
    logic [4*DIGITS-1:0] opa;
    logic [4*DIGITS-1:0] opb;
    logic [1:0]          st;
    logic [2:0]          scan_st;
    // key_valid is a one-clock strobe with no ready/backpressure: key_code is
    // valid in the strobe clock and stays held until the next strobe.
    logic                key_valid;
    logic [7:0]          key_code;
    logic                overflow;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   dig_sel;

    modport master (
        output row, opa, opb, st, scan_st, key_valid, key_code, overflow, seg, dig_sel,
        input  col
    );

    modport slave (
        input  row, opa, opb, st, scan_st, key_valid, key_code, overflow, seg, dig_sel,
        output col
    );
endinterface

// File: rtl/keypad_scanner.sv
// Row scanner with press/release debounce; emits one key_valid strobe per
// debounced press and holds the key code until the next one.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_CYC = 4,
    parameter int DEB_CYC  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col,
    output logic [ROWS-1:0] row,
    output logic [2:0]      scan_st,
    output logic            key_valid,
    output logic [7:0]      key_code
);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int STW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int DTW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    scan_state_t     state;
    logic [RW-1:0]   row_idx;
    logic [RW-1:0]   row_next;
    logic [STW-1:0]  scan_tmr;
    logic [DTW-1:0]  deb_tmr;
    logic [COLS-1:0] pat;
    logic [CW-1:0]   hit_col;
    logic [CW-1:0]   low_col;

    // Lowest set column wins when several keys on one row are down.
    always_comb begin
        low_col = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col[c]) low_col = CW'(c);
        end
    end

    assign row_next = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
    assign row      = ROWS'(1) << row_idx;
    assign scan_st  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            row_idx   <= '0;
            scan_tmr  <= '0;
            deb_tmr   <= '0;
            pat       <= '0;
            hit_col   <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (|col) begin
                        pat     <= col;
                        hit_col <= low_col;
                        deb_tmr <= '0;
                        state   <= DEBOUNCE;
                    end else if (scan_tmr == STW'(SCAN_CYC - 1)) begin
                        scan_tmr <= '0;
                        row_idx  <= row_next;
                    end else begin
                        scan_tmr <= scan_tmr + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (col != pat) begin
                        state    <= SCAN;
                        row_idx  <= row_next;
                        scan_tmr <= '0;
                    end else if (deb_tmr == DTW'(DEB_CYC - 1)) begin
                        state     <= PRESSED;
                        key_valid <= 1'b1;
                        key_code  <= 8'(int'(row_idx) * COLS + int'(hit_col));
                    end else begin
                        deb_tmr <= deb_tmr + 1'b1;
                    end
                end
                PRESSED: begin
                    if (col == '0) begin
                        state   <= RELEASE;
                        deb_tmr <= '0;
                    end
                end
                RELEASE: begin
                    // A bounce back to a pressed pattern is the same press.
                    if (col != '0) begin
                        state <= PRESSED;
                    end else if (deb_tmr == DTW'(DEB_CYC - 1)) begin
                        state    <= SCAN;
                        row_idx  <= row_next;
                        scan_tmr <= '0;
                    end else begin
                        deb_tmr <= deb_tmr + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: rtl/keypad_bcd_entry.sv
// Two-operand BCD entry from a scanned keypad, with a multiplexed display of
// the operand currently being edited.
module keypad_bcd_entry
    import keypad_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int DIGITS      = 4,
    parameter int SCAN_CYC    = 4,
    parameter int DEB_CYC     = 16,
    parameter int REFRESH_CYC = 8
) (
    input  logic                clk,
    input  logic                rst,
    keypad_bcd_entry_if.master  kif
);
    localparam int CNTW = $clog2(DIGITS + 1);
    localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RTW  = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    logic       kv;
    logic [7:0] kc;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_CYC(SCAN_CYC), .DEB_CYC(DEB_CYC)
    ) u_scanner (
        .clk(clk), .rst(rst), .col(kif.col), .row(kif.row),
        .scan_st(kif.scan_st), .key_valid(kv), .key_code(kc)
    );

    entry_state_t        st;
    logic [4*DIGITS-1:0] opa, opb, act_op, new_op;
    logic [CNTW-1:0]     cnt_a, cnt_b, act_cnt, new_cnt;
    logic                ovf, set_ovf, clr_ovf;

    // Edit result for the operand being entered; the sequential block only
    // chooses where to store it.
    always_comb begin
        act_op  = (st == ENTER_A) ? opa : opb;
        act_cnt = (st == ENTER_A) ? cnt_a : cnt_b;
        new_op  = act_op;
        new_cnt = act_cnt;
        set_ovf = 1'b0;
        clr_ovf = 1'b0;
        if (kc < 8'd10) begin
            if (act_cnt == CNTW'(DIGITS)) begin
                set_ovf = 1'b1;
            end else begin
                new_op  = {act_op[4*DIGITS-5:0], kc[3:0]};
                new_cnt = act_cnt + 1'b1;
            end
        end else if (kc == KEY_BACKSPACE) begin
            new_op = {4'h0, act_op[4*DIGITS-1:4]};
            if (act_cnt != '0) new_cnt = act_cnt - 1'b1;
        end else if (kc == KEY_CLEAR) begin
            new_op  = '0;
            new_cnt = '0;
            clr_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= ENTER_A;
            opa   <= '0;
            opb   <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
            ovf   <= 1'b0;
        end else if (kv) begin
            if (st == DONE) begin
                if (kc == KEY_ENTER) begin
                    st    <= ENTER_A;
                    opa   <= '0;
                    opb   <= '0;
                    cnt_a <= '0;
                    cnt_b <= '0;
                    ovf   <= 1'b0;
                end
            end else begin
                if (st == ENTER_A) begin
                    opa   <= new_op;
                    cnt_a <= new_cnt;
                end else begin
                    opb   <= new_op;
                    cnt_b <= new_cnt;
                end
                if (set_ovf)      ovf <= 1'b1;
                else if (clr_ovf) ovf <= 1'b0;
                if (kc == KEY_ENTER) st <= (st == ENTER_A) ? ENTER_B : DONE;
            end
        end
    end

    logic [DW-1:0]     dig_idx;
    logic [RTW-1:0]    ref_tmr;
    logic [6:0]        seg_r;
    logic [DIGITS-1:0] sel_r;

    // seg and dig_sel are registered from the same digit index so they always
    // change together.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_idx <= '0;
            ref_tmr <= '0;
            seg_r   <= 7'h3F;
            sel_r   <= DIGITS'(1);
        end else begin
            if (ref_tmr == RTW'(REFRESH_CYC - 1)) begin
                ref_tmr <= '0;
                dig_idx <= (dig_idx == DW'(DIGITS - 1)) ? '0 : dig_idx + 1'b1;
            end else begin
                ref_tmr <= ref_tmr + 1'b1;
            end
            seg_r <= seg7(act_op[{dig_idx, 2'b00} +: 4]);
            sel_r <= DIGITS'(1) << dig_idx;
        end
    end

    assign kif.opa       = opa;
    assign kif.opb       = opb;
    assign kif.st        = st;
    assign kif.key_valid = kv;
    assign kif.key_code  = kc;
    assign kif.overflow  = ovf;
    assign kif.seg       = seg_r;
    assign kif.dig_sel   = sel_r;
endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Randomised scoreboard bench for keypad_bcd_entry against a decimal-value
// model of the two operands.
module tb_keypad_bcd_entry;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ROWS*COLS-1:0] keys = '0;

  keypad_bcd_entry_if #(.ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS)) kif ();

  keypad_bcd_entry #(
    .ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS),
    .SCAN_CYC(4), .DEB_CYC(16), .REFRESH_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .kif(kif)
  );

  // clock / keypad matrix
  always #5 clk = ~clk;

  always_comb begin
    kif.col = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (kif.row[r] && keys[r*COLS+c]) kif.col[c] = 1'b1;
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic prev_kv = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // reference model: operands held as plain decimal numbers
  int m_st = 0;
  int va = 0, vb = 0, ca = 0, cb = 0;
  bit m_ov = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st = 0; va = 0; vb = 0; ca = 0; cb = 0; m_ov = 0;
  endtask

  task automatic model_apply(input int code);
    if (m_st == 2) begin
      if (code == 10) model_reset();
    end else if (code < 10) begin
      if (m_st == 0) begin
        if (ca == DIGITS) m_ov = 1; else begin va = va * 10 + code; ca++; end
      end else begin
        if (cb == DIGITS) m_ov = 1; else begin vb = vb * 10 + code; cb++; end
      end
    end else if (code == 12) begin
      if (m_st == 0) begin va = va / 10; if (ca > 0) ca--; end
      else begin vb = vb / 10; if (cb > 0) cb--; end
    end else if (code == 11) begin
      if (m_st == 0) begin va = 0; ca = 0; end else begin vb = 0; cb = 0; end
      m_ov = 0;
    end else if (code == 10) begin
      m_st = m_st + 1;
    end
  endtask

  // monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (kif.key_valid) begin
      if (prev_kv) begin
        checks++; errors++;
        $display("FAIL key_valid_width actual=2+ clocks expected=1 at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_key_valid actual=code %0d expected=no pulse at %0t",
                 kif.key_code, $time);
      end else begin
        chk("key_code", {24'h0, kif.key_code}, {24'h0, exp_q.pop_front()});
      end
    end
    prev_kv = kif.key_valid;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_model(input string tag);
    @(negedge clk);
    chk({tag, "_opa"}, {16'h0, kif.opa}, {16'h0, to_bcd(va)});
    chk({tag, "_opb"}, {16'h0, kif.opb}, {16'h0, to_bcd(vb)});
    chk({tag, "_st"}, {30'h0, kif.st}, 32'(m_st));
    chk({tag, "_ovf"}, {31'h0, kif.overflow}, {31'h0, m_ov});
  endtask

  task automatic press(input int code, input int hold);
    exp_q.push_back(8'(code));
    model_apply(code);
    keys[code] = 1'b1;
    tick(hold);
    keys[code] = 1'b0;
    tick(40);
    @(negedge clk);
    chk("key_code_held", {24'h0, kif.key_code}, 32'(code));
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_row"}, {28'h0, kif.row}, 32'h1);
    chk({tag, "_scan_st"}, {29'h0, kif.scan_st}, 32'h0);
    chk({tag, "_st"}, {30'h0, kif.st}, 32'h0);
    chk({tag, "_opa"}, {16'h0, kif.opa}, 32'h0);
    chk({tag, "_opb"}, {16'h0, kif.opb}, 32'h0);
    chk({tag, "_key_valid"}, {31'h0, kif.key_valid}, 32'h0);
    chk({tag, "_key_code"}, {24'h0, kif.key_code}, 32'h0);
    chk({tag, "_ovf"}, {31'h0, kif.overflow}, 32'h0);
    chk({tag, "_dig_sel"}, {28'h0, kif.dig_sel}, 32'h1);
    chk({tag, "_seg"}, {25'h0, kif.seg}, 32'h3F);
  endtask

  task automatic wait_scan_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (kif.scan_st != s && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reached"}, {29'h0, kif.scan_st}, {29'h0, s});
  endtask

  initial begin
    int seq1[6];
    int seq2[6];
    int code;
    int idx;
    logic [15:0] bcd;
    seq1 = '{11, 1, 2, 3, 4, 7};
    seq2 = '{11, 9, 10, 4, 2, 10};

    // reset values
    rst = 1'b1;
    tick(3);
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // single held key
    press(5, 40);
    check_model("key5");
    chk("key5_opa_const", {16'h0, kif.opa}, 32'h0005);

    // fill past capacity, then backspace
    foreach (seq1[i]) begin
      press(seq1[i], 50);
      check_model("seq1");
    end
    chk("full_opa_const", {16'h0, kif.opa}, 32'h1234);
    chk("full_ovf_const", {31'h0, kif.overflow}, 32'h1);
    press(12, 50);
    check_model("bksp");
    chk("bksp_opa_const", {16'h0, kif.opa}, 32'h0123);

    // bouncing contact never debounces
    keys[6] = 1'b1;
    wait_scan_state(3'd1, "bounce_deb");
    for (int i = 0; i < 12; i++) begin
      tick(5);
      keys[6] = ~keys[6];
    end
    keys[6] = 1'b0;
    tick(40);
    @(negedge clk);
    chk("bounce_scan_st", {29'h0, kif.scan_st}, 32'h0);

    // two operands, done, then wrap back
    foreach (seq2[i]) begin
      press(seq2[i], 50);
      check_model("seq2");
    end
    chk("done_opa_const", {16'h0, kif.opa}, 32'h0009);
    chk("done_opb_const", {16'h0, kif.opb}, 32'h0042);
    chk("done_st_const", {30'h0, kif.st}, 32'h2);
    press(10, 50);
    check_model("wrap");
    chk("wrap_st_const", {30'h0, kif.st}, 32'h0);

    // display multiplex on a known operand
    press(8, 45); press(3, 45); press(6, 45); press(1, 45);
    check_model("disp");
    bcd = to_bcd(va);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      chk("dig_sel_onehot", {31'h0, $onehot(kif.dig_sel)}, 32'h1);
      idx = 0;
      for (int d = 0; d < DIGITS; d++) if (kif.dig_sel[d]) idx = d;
      chk("seg_image", {25'h0, kif.seg}, {25'h0, seg_tab[bcd[4*idx +: 4]]});
    end

    // random keys over the full code space
    for (int k = 0; k < 30; k++) begin
      code = $urandom_range(0, ROWS*COLS-1);
      press(code, $urandom_range(40, 60));
      check_model("rand");
    end

    // two columns on row 0 together: lowest column wins
    exp_q.push_back(8'd0);
    model_apply(0);
    keys[0] = 1'b1; keys[2] = 1'b1;
    tick(50);
    keys[0] = 1'b0; keys[2] = 1'b0;
    tick(40);
    @(negedge clk);
    chk("multi_key_code", {24'h0, kif.key_code}, 32'h0);
    check_model("multi");

    // reset while the key is held in PRESSED
    exp_q.push_back(8'd5);
    keys[5] = 1'b1;
    wait_scan_state(3'd2, "rst_pressed");
    rst = 1'b1;
    keys[5] = 1'b0;
    model_reset();
    tick(3);
    check_reset("rst_mid");
    rst = 1'b0;
    tick(60);
    check_model("post_rst");

    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/keypad_bcd_entry.md
KEYPAD_BCD_ENTRY -- requirements
Module: keypad_bcd_entry

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad rows driven.
REQ-002 SHALL have parameter COLS, default 4, number of keypad columns sensed; ROWS*COLS >= 13.
REQ-003 SHALL have parameter DIGITS, default 4, BCD digits per operand.
REQ-004 SHALL have parameter SCAN_CYC, default 4, clocks per row during scanning.
REQ-005 SHALL have parameter DEB_CYC, default 16, stable clocks required for press and for release.
REQ-006 SHALL have parameter REFRESH_CYC, default 8, clocks per display digit.
REQ-007 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-009 SHALL have port row  out  ROWS  one-hot, active-high row drive.
REQ-010 SHALL have port col  in  COLS  active-high column sense; bit high means key pressed on the driven row.
REQ-011 SHALL have port opa  out  4*DIGITS  operand A, BCD, digit 0 in bits [3:0].
REQ-012 SHALL have port opb  out  4*DIGITS  operand B, same format as opa.
REQ-013 SHALL have port st  out  2  entry state: 0 ENTER_A, 1 ENTER_B, 2 DONE.
REQ-014 SHALL have port scan_st  out  3  scanner state: 0 SCAN, 1 DEBOUNCE, 2 PRESSED, 3 RELEASE.
REQ-015 SHALL have port key_valid  out  1  one-clock pulse per accepted key press.
REQ-016 SHALL have port key_code  out  8  code of the last accepted key, held between pulses.
REQ-017 SHALL have port overflow  out  1  sticky flag, set when a digit is dropped because the operand is full.
REQ-018 SHALL have port seg  out  7  active-high segments {g,f,e,d,c,b,a} for the selected digit.
REQ-019 SHALL have port dig_sel  out  DIGITS  one-hot, active-high digit enable.

Function
REQ-020 Key code SHALL equal r*COLS+c; codes 0-9 are digits, 10 ENTER, 11 CLEAR, 12 BACKSPACE, and all other codes SHALL be ignored by entry logic.
REQ-021 In SCAN, row SHALL advance r to (r+1) mod ROWS every SCAN_CYC clocks, starting at row 0.
REQ-022 In SCAN, any col bit high SHALL latch row and col pattern and move to DEBOUNCE, freezing row.
REQ-023 If several col bits are high, the lowest index SHALL win.
REQ-024 DEBOUNCE SHALL move to PRESSED after DEB_CYC consecutive clocks of the identical col pattern; any change SHALL return to SCAN and resume scanning at the next row.
REQ-025 Entry into PRESSED SHALL pulse key_valid for exactly one clock, with key_code updated in that same clock.
REQ-026 PRESSED SHALL move to RELEASE when col is all-zero; RELEASE SHALL return to SCAN after DEB_CYC consecutive all-zero clocks, and any nonzero col SHALL go back to PRESSED without a new pulse.
REQ-027 A digit key in ENTER_A/ENTER_B SHALL shift the active operand left one digit and insert the new digit at digit 0, taking effect the clock after key_valid.
REQ-028 A digit key when the active operand already holds DIGITS entered digits SHALL leave the operand unchanged and set overflow.
REQ-029 BACKSPACE SHALL shift the active operand right one digit, fill the top digit with 0, and decrement the entered count, saturating at 0.
REQ-030 CLEAR SHALL zero the active operand and its count and clear overflow.
REQ-031 ENTER SHALL move ENTER_A to ENTER_B and ENTER_B to DONE.
REQ-032 In DONE, digit, BACKSPACE and CLEAR keys SHALL be ignored; ENTER SHALL zero both operands, both counts and overflow, and go to ENTER_A.
REQ-033 The display SHALL show the active operand (A in ENTER_A; B in ENTER_B and DONE), cycling dig_sel from digit 0 upward every REFRESH_CYC clocks, with seg the hex-to-7-segment image of that digit.

Reset
REQ-034 While rst is high at a clock edge: row=1 (row 0 driven), scan_st=SCAN, st=ENTER_A, opa=opb=0, counts=0, key_valid=0, key_code=0, overflow=0, dig_sel=1, seg=image of 0 (7'h3F), and all timers=0.
REQ-035 Reset asserted mid-debounce or mid-press SHALL abandon the key with no key_valid pulse.

Structure
REQ-036 Package keypad_pkg SHALL hold the scanner and entry state encodings, key-code constants (ENTER, CLEAR, BACKSPACE), and the 7-segment lookup function.
REQ-037 Scanning and debounce (REQ-021..026) SHALL be a sub-module keypad_scanner, with entry, operand and display logic in the top module.

Verification
REQ-038 Hold key code 5 (r1,c1) for 40 clocks, then release -> exactly one key_valid, key_code=5, opa=16'h0005.
REQ-039 Key sequence 1,2,3,4,7 -> opa=16'h1234, overflow=1; then BACKSPACE -> opa=16'h0123.
REQ-040 Col bit toggling every 5 clocks during DEBOUNCE (DEB_CYC=16) -> no key_valid, scan_st returns to SCAN.
REQ-041 Sequence 9, ENTER, 4, 2, ENTER -> opa=16'h0009, opb=16'h0042, st=DONE; further ENTER -> all zero, st=ENTER_A.
REQ-042 Keys at c0 and c2 pressed together on row 0 -> key_code=0 only; rst pulsed in PRESSED -> all outputs at reset values and no pulse after release.
